// File: rtl/inst_fetch_if.sv
// Fetch-unit bus: ROM address/data, decode handshake, redirect and interrupt lines.
// The master side is the fetch unit, the slave side is the surrounding core/ROM.
interface inst_fetch_if;
   localparam int unsigned XLEN = 32;

   logic [XLEN-1:0] rom_addr;
   logic [XLEN-1:0] rom_inst;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_inst;
   logic [XLEN-1:0] out_pc;
   logic [XLEN-1:0] out_pc4;
   logic            redir_valid;
   logic [XLEN-1:0] redir_pc;
   logic            intr;
   logic            ie;
   logic            intr_ack;
   logic [XLEN-1:0] epc;

   modport master (
      output rom_addr, out_valid, out_inst, out_pc, out_pc4, intr_ack, epc,
      input  rom_inst, out_ready, redir_valid, redir_pc, intr, ie
   );

   modport slave (
      input  rom_addr, out_valid, out_inst, out_pc, out_pc4, intr_ack, epc,
      output rom_inst, out_ready, redir_valid, redir_pc, intr, ie
   );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch: pc register driving the ROM, a 2-entry {inst, pc} buffer toward decode,
// redirect handling and interrupt entry taken only when decode accepts an instruction.
module inst_fetch #(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter logic [31:0] INTR_VECTOR = 32'h0000_0008
) (
   input logic         clk,
   input logic         clrn,
   inst_fetch_if.master bus
);
   localparam int unsigned XLEN  = 32;
   localparam int unsigned DEPTH = 2;
   localparam int unsigned CW    = 2;

   typedef struct packed {
      logic [XLEN-1:0] inst;
      logic [XLEN-1:0] pc;
   } entry_t;

   logic [XLEN-1:0] pc_q, pc_d;
   logic [CW-1:0]   count_q, count_d;
   entry_t          ent_q [DEPTH];
   entry_t          ent_d [DEPTH];
   logic [XLEN-1:0] epc_q, epc_d;
   logic            intr_ack_q, intr_ack_d;

   logic            pop_c, push_c, flush_c, intr_take_c, wr_idx_c;
   logic [CW-1:0]   fill_c;

   // Handshake and flush decode.
   always_comb begin
      pop_c       = (count_q != CW'(0)) && bus.out_ready;
      intr_take_c = bus.intr && bus.ie && pop_c && !bus.redir_valid;
      flush_c     = bus.redir_valid || intr_take_c;
      push_c      = ((count_q < CW'(DEPTH)) || pop_c) && !flush_c;
      fill_c      = count_q - CW'(pop_c);
      wr_idx_c    = (fill_c == CW'(1));
   end

   // Next-state: redirect beats interrupt; otherwise shift on pop, write tail on push.
   always_comb begin
      pc_d       = pc_q;
      count_d    = count_q;
      ent_d      = ent_q;
      epc_d      = epc_q;
      intr_ack_d = 1'b0;
      if (bus.redir_valid) begin
         count_d = CW'(0);
         pc_d    = bus.redir_pc & ~XLEN'(3);
      end else if (intr_take_c) begin
         count_d    = CW'(0);
         pc_d       = INTR_VECTOR;
         epc_d      = ent_q[0].pc + XLEN'(4);
         intr_ack_d = 1'b1;
      end else begin
         if (pop_c) begin
            ent_d[0] = ent_q[1];
         end
         if (push_c) begin
            ent_d[wr_idx_c] = '{inst: bus.rom_inst, pc: pc_q};
            pc_d            = pc_q + XLEN'(4);
         end
         count_d = fill_c + CW'(push_c);
      end
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         pc_q       <= RESET_PC;
         count_q    <= CW'(0);
         ent_q      <= '{default: '0};
         epc_q      <= '0;
         intr_ack_q <= 1'b0;
      end else begin
         pc_q       <= pc_d;
         count_q    <= count_d;
         ent_q      <= ent_d;
         epc_q      <= epc_d;
         intr_ack_q <= intr_ack_d;
      end
   end

   assign bus.rom_addr  = pc_q;
   assign bus.out_valid = (count_q != CW'(0));
   assign bus.out_inst  = ent_q[0].inst;
   assign bus.out_pc    = ent_q[0].pc;
   assign bus.out_pc4   = ent_q[0].pc + XLEN'(4);
   assign bus.intr_ack  = intr_ack_q;
   assign bus.epc       = epc_q;
endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed vector table, hand-written corner sequences, then random
// traffic against a queue-based reference model.
module tb_inst_fetch;
   localparam logic [31:0] VEC = 32'h0000_0008;

   logic clk  = 1'b0;
   logic clrn = 1'b0;
   int   total = 0;
   int   bad   = 0;

   inst_fetch_if bus ();

   inst_fetch #(.RESET_PC(32'h0), .INTR_VECTOR(VEC)) dut (
      .clk (clk),
      .clrn(clrn),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // ROM image: known program words, address-derived pattern elsewhere.
   function automatic logic [31:0] rom_fn(input logic [31:0] a);
      case (a)
         32'h00: rom_fn = 32'h0800_001d;
         32'h04: rom_fn = 32'h0000_0000;
         32'h08: rom_fn = 32'h401a_6800;
         32'h74: rom_fn = 32'h2008_000f;
         32'h80: rom_fn = 32'h8c09_004c;
         default: rom_fn = a ^ 32'hDEAD_0000;
      endcase
   endfunction

   assign bus.rom_inst = rom_fn(bus.rom_addr);

   // Reference model: fetch pc plus a queue of pending {inst, pc}.
   typedef struct { logic [31:0] inst; logic [31:0] pc; } ment_t;
   ment_t       mq[$];
   logic [31:0] m_pc  = 32'h0;
   logic [31:0] m_epc = 32'h0;
   logic        m_ack = 1'b0;

   function automatic void model_reset();
      mq.delete();
      m_pc  = 32'h0;
      m_epc = 32'h0;
      m_ack = 1'b0;
   endfunction

   function automatic void model_step(input logic rdy, rv, input logic [31:0] rpc,
                                      input logic irq, ien);
      bit acc;
      acc = (mq.size() != 0) && rdy;
      m_ack = 1'b0;
      if (rv) begin
         mq.delete();
         m_pc = {rpc[31:2], 2'b00};
      end else if (acc && irq && ien) begin
         m_epc = mq[0].pc + 32'd4;
         mq.delete();
         m_pc  = VEC;
         m_ack = 1'b1;
      end else begin
         if (acc) void'(mq.pop_front());
         if (mq.size() < 2) begin
            mq.push_back('{inst: rom_fn(m_pc), pc: m_pc});
            m_pc = m_pc + 32'd4;
         end
      end
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // Drive one cycle's inputs at the falling edge, advance the model, sample after the rise.
   task automatic cyc(input logic rdy, rv, input logic [31:0] rpc, input logic irq, ien);
      @(negedge clk);
      bus.out_ready   = rdy;
      bus.redir_valid = rv;
      bus.redir_pc    = rpc;
      bus.intr        = irq;
      bus.ie          = ien;
      model_step(rdy, rv, rpc, irq, ien);
      @(posedge clk);
      #1;
   endtask

   task automatic chk_model(input string tag);
      chk({tag, ".valid"}, 32'(bus.out_valid), 32'(mq.size() != 0));
      chk({tag, ".rom_addr"}, bus.rom_addr, m_pc);
      chk({tag, ".ack"}, 32'(bus.intr_ack), 32'(m_ack));
      chk({tag, ".epc"}, bus.epc, m_epc);
      if (mq.size() != 0) begin
         chk({tag, ".pc"}, bus.out_pc, mq[0].pc);
         chk({tag, ".inst"}, bus.out_inst, mq[0].inst);
         chk({tag, ".pc4"}, bus.out_pc4, mq[0].pc + 32'd4);
      end
   endtask

   typedef struct {
      logic rdy; logic rv; logic [31:0] rpc; logic irq; logic ien;
      logic ev; logic [31:0] epc_head; logic [31:0] einst; logic [31:0] erom;
      logic eack; logic [31:0] eepc;
   } vec_t;

   function automatic vec_t mk(input logic rdy, rv, input logic [31:0] rpc,
                               input logic irq, ien, ev, input logic [31:0] ph, ei, er,
                               input logic ea, input logic [31:0] ee);
      vec_t v;
      v.rdy = rdy; v.rv = rv; v.rpc = rpc; v.irq = irq; v.ien = ien;
      v.ev = ev; v.epc_head = ph; v.einst = ei; v.erom = er; v.eack = ea; v.eepc = ee;
      return v;
   endfunction

   vec_t vt[$];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.out_ready   = 1'b0;
      bus.redir_valid = 1'b0;
      bus.redir_pc    = 32'h0;
      bus.intr        = 1'b0;
      bus.ie          = 1'b0;
      model_reset();

      //        rdy rv rpc    irq ie  ev head   inst          rom    ack epc
      vt.push_back(mk(0, 0, 0,     0, 0, 1, 32'h00, 32'h0800001d, 32'h04, 0, 0));
      vt.push_back(mk(0, 0, 0,     0, 0, 1, 32'h00, 32'h0800001d, 32'h08, 0, 0));
      vt.push_back(mk(0, 0, 0,     0, 0, 1, 32'h00, 32'h0800001d, 32'h08, 0, 0));
      vt.push_back(mk(0, 0, 0,     0, 0, 1, 32'h00, 32'h0800001d, 32'h08, 0, 0));
      vt.push_back(mk(0, 0, 0,     0, 0, 1, 32'h00, 32'h0800001d, 32'h08, 0, 0));
      vt.push_back(mk(1, 0, 0,     0, 0, 1, 32'h04, 32'h00000000, 32'h0c, 0, 0));
      vt.push_back(mk(1, 0, 0,     0, 0, 1, 32'h08, 32'h401a6800, 32'h10, 0, 0));
      vt.push_back(mk(1, 1, 32'h76, 0, 0, 0, 32'h00, 32'h00000000, 32'h74, 0, 0));
      vt.push_back(mk(1, 0, 0,     0, 0, 1, 32'h74, 32'h2008000f, 32'h78, 0, 0));
      vt.push_back(mk(0, 1, 32'h80, 0, 0, 0, 32'h00, 32'h00000000, 32'h80, 0, 0));
      vt.push_back(mk(0, 0, 0,     0, 0, 1, 32'h80, 32'h8c09004c, 32'h84, 0, 0));
      vt.push_back(mk(1, 0, 0,     1, 1, 0, 32'h00, 32'h00000000, 32'h08, 1, 32'h84));
      vt.push_back(mk(1, 0, 0,     1, 1, 1, 32'h08, 32'h401a6800, 32'h0c, 0, 32'h84));
      vt.push_back(mk(1, 1, 32'h40, 1, 1, 0, 32'h00, 32'h00000000, 32'h40, 0, 32'h84));
      vt.push_back(mk(0, 0, 0,     1, 1, 1, 32'h40, 32'hdead0040, 32'h44, 0, 32'h84));
      vt.push_back(mk(1, 0, 0,     1, 0, 1, 32'h44, 32'hdead0044, 32'h48, 0, 32'h84));
      vt.push_back(mk(1, 0, 0,     0, 0, 1, 32'h48, 32'hdead0048, 32'h4c, 0, 32'h84));

      // Reset state.
      repeat (2) @(posedge clk);
      #1;
      chk("rst.valid", 32'(bus.out_valid), 32'h0);
      chk("rst.pc", bus.out_pc, 32'h0);
      chk("rst.inst", bus.out_inst, 32'h0);
      chk("rst.rom_addr", bus.rom_addr, 32'h0);
      chk("rst.ack", 32'(bus.intr_ack), 32'h0);
      chk("rst.epc", bus.epc, 32'h0);
      #1 clrn = 1'b1;

      for (int i = 0; i < vt.size(); i++) begin
         cyc(vt[i].rdy, vt[i].rv, vt[i].rpc, vt[i].irq, vt[i].ien);
         chk($sformatf("v%0d.valid", i), 32'(bus.out_valid), 32'(vt[i].ev));
         chk($sformatf("v%0d.rom_addr", i), bus.rom_addr, vt[i].erom);
         chk($sformatf("v%0d.ack", i), 32'(bus.intr_ack), 32'(vt[i].eack));
         chk($sformatf("v%0d.epc", i), bus.epc, vt[i].eepc);
         if (vt[i].ev) begin
            chk($sformatf("v%0d.pc", i), bus.out_pc, vt[i].epc_head);
            chk($sformatf("v%0d.inst", i), bus.out_inst, vt[i].einst);
         end
      end

      // pc wraps from the top of the address space.
      cyc(0, 1, 32'hFFFF_FFFE, 0, 0);
      chk("wrap.rom_addr0", bus.rom_addr, 32'hFFFF_FFFC);
      cyc(0, 0, 0, 0, 0);
      chk("wrap.pc", bus.out_pc, 32'hFFFF_FFFC);
      chk("wrap.pc4", bus.out_pc4, 32'h0);
      chk("wrap.inst", bus.out_inst, 32'h2152_FFFC);
      chk("wrap.rom_addr1", bus.rom_addr, 32'h0);
      cyc(0, 0, 0, 0, 0);
      chk("wrap.rom_addr2", bus.rom_addr, 32'h4);

      // Asynchronous reset mid-cycle with a full buffer.
      cyc(0, 1, 32'h100, 0, 0);
      cyc(0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);
      chk("arst.pre_rom_addr", bus.rom_addr, 32'h108);
      @(negedge clk);
      #2 clrn = 1'b0;
      #1;
      chk("arst.valid", 32'(bus.out_valid), 32'h0);
      chk("arst.rom_addr", bus.rom_addr, 32'h0);
      chk("arst.pc", bus.out_pc, 32'h0);
      chk("arst.epc", bus.epc, 32'h0);
      model_reset();
      #1 clrn = 1'b1;
      model_step(bus.out_ready, bus.redir_valid, bus.redir_pc, bus.intr, bus.ie);
      @(posedge clk);
      #1;
      chk("arst.refetch_pc", bus.out_pc, 32'h0);
      chk("arst.refetch_inst", bus.out_inst, 32'h0800_001d);
      chk_model("arst");

      // Random traffic against the reference model.
      for (int n = 0; n < 2000; n++) begin
         cyc(($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0), $urandom,
             ($urandom_range(0, 4) == 0), 1'($urandom_range(0, 1)));
         chk_model($sformatf("rnd%0d", n));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
